aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule.
- Takes a 128-bit cipher key and emits the 11 round keys (round 0..10) one per accepted handshake.
- Feeds the AddRoundKey stage that consumes the MixColumns output in the round datapath.
- Round keys use the same column/byte packing as the state bus:
  - bits [127:96] = word w0 (column 0), MSB byte first
  - down to bits [31:0] = w3.

Parameters:
- NUM_ROUNDS, 10, index of last round key emitted. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request expansion of key_in; sampled only in IDLE
- key_in  input  128  cipher key; captured on the cycle start is accepted
- rk_out  output  128  current round key
- rk_round  output  4  round index of rk_out, 0..10
- rk_valid  output  1  rk_out/rk_round valid
- rk_ready  input  1  downstream accepts rk_out when rk_valid and rk_ready are both high
- busy  output  1  high whenever state is EMIT
- done  output  1  one-cycle pulse after round 10 key is accepted

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0.
  - Overrides every other input in the same cycle, including mid-expansion; any partial schedule is discarded.
- States: IDLE, EMIT.
- IDLE:
  - start=1 at cycle t latches key_in into the key register, rk_round<=0, state<=EMIT.
  - rk_valid=1 and busy=1 from cycle t+1; rk_out=key_in (round 0 key = cipher key).
  - start=0: remain in IDLE.
- EMIT:
  - rk_valid=1. While rk_ready=0, rk_out and rk_round hold stable, with no internal advance.
  - Handshake with rk_round<10:
    - Next cycle rk_out = next round key, rk_round+1.
    - rk_valid stays high, so throughput is 1 key/cycle under continuous rk_ready.
  - Handshake with rk_round==10: next cycle state=IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle.
  - rk_out and rk_round hold their final values after completion until the next start.
- start while in EMIT is ignored: no restart, no key capture.
- start asserted in the same cycle done is high is accepted, because the state is already IDLE.
- Next-key computation from current words w0..w3 at round r:
  - temp = SubWord(RotWord(w3)) XOR {Rcon[r+1], 24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}.
  - SubWord applies the AES forward S-box to each byte. The S-box is a 256-entry table held inside this block; four parallel lookups per cycle.
  - w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex), selected by rk_round; no runtime GF multiply.
- All outputs are registered; no combinational path from rk_ready or start to any output.
- key_in changes after start is accepted have no effect.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 continuous:
  - rk_round 0..10 on 11 consecutive cycles starting 1 cycle after start.
  - round1 = a0fafe1788542cb123a339392a6c7605; round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses once, 1 cycle after round 10 is accepted.
- All-zero key:
  - round1 = 62636363626363636263636362636363.
  - round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: rk_ready low for 3 cycles at round 4 -> rk_out/rk_round stable for all 3 stalled cycles; sequence resumes with correct round 5; total keys still 11, no duplicates or skips.
- start pulsed during EMIT with a different key_in -> ignored; output sequence matches the original key.
- rst asserted while rk_round=6 -> next cycle all outputs 0 and IDLE. A new start with the FIPS key then yields round 0 = 2b7e1516... correctly.
- Back-to-back: start asserted in the done cycle with the zero key -> accepted; round 0 = 0 appears on the next cycle with rk_valid=1.

Source files
------------

// File: rtl/aes_key_expand_if.sv
// Round-key handshake bundle between the key schedule and the AddRoundKey stage.
// The master drives start/key/ready; the slave (key schedule) returns the round keys.
interface aes_key_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  rk_out, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_out, rk_round, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per accepted handshake, round 0..10,
// with a single S-box stage (four parallel lookups) evaluated on the current key.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10
) (
  input logic             clk,
  input logic             rst,
  aes_key_expand_if.slave kx
);

  if (NUM_ROUNDS != 10) begin : g_cfg_err
    $error("aes_key_expand: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  // Rcon for the key being produced, i.e. Rcon[round+1].
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
  logic [127:0] next_rk;

  assign {w0, w1, w2, w3} = rk_q;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(round_q), 24'h0};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q    <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (kx.start) state_d = EMIT;
      EMIT:    if (kx.rk_ready && round_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key/round only move on an accepted handshake; they hold after completion.
  always_comb begin
    rk_d    = rk_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (kx.start) begin
          rk_d    = kx.key_in;
          round_d = 4'd0;
        end
      end
      EMIT: begin
        if (kx.rk_ready) begin
          if (round_q == LAST) begin
            done_d = 1'b1;
          end else begin
            rk_d    = next_rk;
            round_d = round_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign kx.rk_out   = rk_q;
  assign kx.rk_round = round_q;
  assign kx.rk_valid = (state_q == EMIT);
  assign kx.busy     = (state_q == EMIT);
  assign kx.done     = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: S-box built from GF(2^8) inversion + affine map, schedule
// computed FIPS-197 style over a 44-word array, compared against every emitted key.
module tb_aes_key_expand;

  logic clk = 1'b0;
  logic rst;
  aes_key_expand_if kx();

  aes_key_expand #(.NUM_ROUNDS(10)) dut (.clk(clk), .rst(rst), .kx(kx));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sb [256];
  logic [31:0]  rc [11];
  logic [127:0] ref_rk [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 32'h0;
    rc[1] = 32'h01000000;
    for (int j = 2; j < 11; j++) rc[j] = {gmul(rc[j-1][31:24], 8'h02), 24'h0};
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ rc[i/4];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [127:0] rk, input logic [3:0] rnd,
                         input logic vld, input logic bsy, input logic dn);
    chk({tag, ".rk_out"},   kx.rk_out,           rk);
    chk({tag, ".rk_round"}, 128'(kx.rk_round),   128'(rnd));
    chk({tag, ".rk_valid"}, 128'(kx.rk_valid),   128'(vld));
    chk({tag, ".busy"},     128'(kx.busy),       128'(bsy));
    chk({tag, ".done"},     128'(kx.done),       128'(dn));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] key);
    model(key);
    kx.key_in = key;
    kx.start  = 1'b1;
    tick();
    kx.start  = 1'b0;
    kx.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Walks rounds 0..10 from the first valid cycle and ends in the done cycle.
  task automatic expect_seq(input int stall_at, input int stall_n, input int poke_at);
    for (int r = 0; r < 11; r++) begin
      chk($sformatf("seq.r%0d", r), kx.rk_out, ref_rk[r]);
      chk_out("seq", ref_rk[r], 4'(r), 1'b1, 1'b1, 1'b0);
      if (r == stall_at) begin
        kx.rk_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk_out($sformatf("stall.r%0d", r), ref_rk[r], 4'(r), 1'b1, 1'b1, 1'b0);
        end
        kx.rk_ready = 1'b1;
      end
      if (r == poke_at) begin
        kx.start  = 1'b1;
        kx.key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      kx.start = 1'b0;
    end
    chk_out("done", ref_rk[10], 4'd10, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    build_tables();
    rst         = 1'b1;
    kx.start    = 1'b0;
    kx.key_in   = '0;
    kx.rk_ready = 1'b1;
    tick();
    tick();
    chk_out("reset", '0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("idle", '0, 4'd0, 1'b0, 1'b0, 1'b0);

    // FIPS-197 key, continuous ready
    do_start(FIPS_KEY);
    chk("fips.ref_r1",  ref_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips.ref_r10", ref_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expect_seq(-1, 0, -1);
    tick();
    chk_out("hold", ref_rk[10], 4'd10, 1'b0, 1'b0, 1'b0);

    // Backpressure at round 4 plus a start poke during EMIT
    do_start(FIPS_KEY);
    expect_seq(4, 3, 2);

    // Back-to-back: start in the done cycle with the zero key
    do_start('0);
    chk("zero.ref_r1",  ref_rk[1],  128'h62636363626363636263636362636363);
    chk("zero.ref_r10", ref_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    expect_seq(-1, 0, -1);

    // Reset while round 6 is on the bus
    tick();
    do_start(FIPS_KEY);
    repeat (6) tick();
    chk_out("pre_rst", ref_rk[6], 4'd6, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst_mid", '0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst_idle", '0, 4'd0, 1'b0, 1'b0, 1'b0);
    do_start(FIPS_KEY);
    expect_seq(-1, 0, -1);

    // Random keys with random stalls and stray starts
    for (int k = 0; k < 5; k++) begin
      tick();
      do_start({$urandom, $urandom, $urandom, $urandom});
      expect_seq(int'($urandom_range(0, 10)), int'($urandom_range(1, 3)),
                 int'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
